// File: rtl/mux_lab_pkg.sv
// Shared types and helpers for the gate-level 4-to-1 mux lab.
// The select decode here is also reused by the mux benches.
package mux_lab_pkg;

  localparam int SEL_W = 2;
  localparam int N_IN  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2
  } state_t;

  function automatic logic [N_IN-1:0] onehot_dec(input logic [SEL_W-1:0] s, input logic e);
    logic [N_IN-1:0] r;
    r = '0;
    if (e) r[s] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level debounce counter, registered rise detect.
// rise is a 1-cycle pulse one cycle after the debounced level goes high.
module btn_debounce #(
  parameter int          DB_W   = 16,
  parameter int unsigned DB_MAX = 49999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic            sync1;
  logic            sync2;
  logic            level_d;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // The level only moves after DB_MAX+1 consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == DB_W'(DB_MAX)) begin
      cnt   <= '0;
      level <= sync2;
    end else begin
      cnt <= cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Mux select sequencer: button-stepped or prescaler-scanned enable/select generation.
// All outputs registered; an advance shows up on the edge after step request or prescaler wrap.
module mux_sel_sequencer
  import mux_lab_pkg::*;
#(
  parameter int          DB_W    = 16,
  parameter int unsigned DB_MAX  = 49999,
  parameter int          DIV_W   = 24,
  parameter int unsigned DIV_MAX = 9999999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_step,
  input  logic             auto_en,
  input  logic             hold,
  output logic             en,
  output logic [SEL_W-1:0] sel,
  output logic [N_IN-1:0]  sel_onehot,
  output logic             step_pulse
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_IN-1:0]    onehot_q;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic               en_q, en_d;
  logic               pulse_q;
  logic               adv;
  logic               auto_s1, auto_s;
  logic               step_req;
  logic               btn_level;

  btn_debounce #(
    .DB_W   (DB_W),
    .DB_MAX (DB_MAX)
  ) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_step),
    .level (btn_level),
    .rise  (step_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_s1 <= 1'b0;
      auto_s  <= 1'b0;
    end else begin
      auto_s1 <= auto_en;
      auto_s  <= auto_s1;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    presc_d = presc_q;
    en_d    = en_q;
    adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        en_d = 1'b0;
        // The first press only wakes the mux up; it does not advance sel.
        if (auto_s) begin
          state_d = ST_AUTO;
          en_d    = 1'b1;
        end else if (step_req) begin
          state_d = ST_MANUAL;
          en_d    = 1'b1;
        end
      end
      ST_MANUAL: begin
        en_d = 1'b1;
        if (auto_s) begin
          state_d = ST_AUTO;
        end else if (step_req && !hold) begin
          adv = 1'b1;
        end
      end
      ST_AUTO: begin
        en_d = 1'b1;
        if (!auto_s) begin
          state_d = ST_MANUAL;
          presc_d = '0;
        end else if (!hold) begin
          if (presc_q == DIV_W'(DIV_MAX)) begin
            presc_d = '0;
            adv     = 1'b1;
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase
    if (adv) sel_d = sel_q + SEL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      presc_q  <= '0;
      en_q     <= 1'b0;
      onehot_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      presc_q  <= presc_d;
      en_q     <= en_d;
      onehot_q <= onehot_dec(sel_d, en_d);
      pulse_q  <= adv;
    end
  end

  assign en         = en_q;
  assign sel        = sel_q;
  assign sel_onehot = onehot_q;
  assign step_pulse = pulse_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Randomized scenario bench for mux_sel_sequencer against an input-history reference model.
module tb_mux_sel_sequencer;

  localparam int DB_MAX   = 3;
  localparam int DIV_MAX  = 4;
  localparam int M_IDLE   = 0;
  localparam int M_MANUAL = 1;
  localparam int M_AUTO   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_step = 1'b0;
  logic       auto_en = 1'b0;
  logic       hold = 1'b0;
  logic       en;
  logic [1:0] sel;
  logic [3:0] sel_onehot;
  logic       step_pulse;
  logic [7:0] dut_vec;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: raw-input delay lines, debounced level, mode, scan count, select.
  bit bq[$];
  bit aq[$];
  bit rq[$];
  bit m_level;
  int m_run;
  int m_mode;
  int m_scan;
  int m_sel;
  bit m_en;
  bit m_pulse;

  mux_sel_sequencer #(
    .DB_W    (16),
    .DB_MAX  (DB_MAX),
    .DIV_W   (24),
    .DIV_MAX (DIV_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_step   (btn_step),
    .auto_en    (auto_en),
    .hold       (hold),
    .en         (en),
    .sel        (sel),
    .sel_onehot (sel_onehot),
    .step_pulse (step_pulse)
  );

  assign dut_vec = {en, sel, sel_onehot, step_pulse};

  always #5 clk = ~clk;

  function automatic void model_reset();
    bq.delete(); bq.push_back(1'b0); bq.push_back(1'b0);
    aq.delete(); aq.push_back(1'b0); aq.push_back(1'b0);
    rq.delete(); rq.push_back(1'b0); rq.push_back(1'b0);
    m_level = 1'b0; m_run = 0; m_mode = M_IDLE; m_scan = 0;
    m_sel = 0; m_en = 1'b0; m_pulse = 1'b0;
  endfunction

  function automatic void model_edge();
    bit s, a, req, rose, adv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = bq.pop_front(); bq.push_back(btn_step);
    a = aq.pop_front(); aq.push_back(auto_en);
    req = rq.pop_front();
    adv = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (a) begin m_mode = M_AUTO; m_en = 1'b1; end
        else if (req) begin m_mode = M_MANUAL; m_en = 1'b1; end
      end
      M_MANUAL: begin
        if (a) m_mode = M_AUTO;
        else if (req && !hold) adv = 1'b1;
      end
      default: begin
        if (!a) begin m_mode = M_MANUAL; m_scan = 0; end
        else if (!hold) begin
          m_scan++;
          if (m_scan == DIV_MAX + 1) begin m_scan = 0; adv = 1'b1; end
        end
      end
    endcase
    m_pulse = adv;
    if (adv) m_sel = (m_sel + 1) % 4;
    rose = 1'b0;
    if (s == m_level) m_run = 0;
    else if (m_run == DB_MAX) begin m_level = s; m_run = 0; rose = s; end
    else m_run++;
    rq.push_back(rose);
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [3:0] oh;
    oh = m_en ? 4'(1 << m_sel) : 4'b0000;
    return {m_en, 2'(m_sel), oh, m_pulse};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      btn_step = 1'($urandom); auto_en = 1'($urandom); hold = 1'($urandom);
      cyc();
      n_checks++;
      if (dut_vec !== 8'h00) $display("FAIL reset_hold got=%b exp=%b", dut_vec, 8'h00); else n_pass++;
    end
    btn_step = 1'b0; auto_en = 1'b0; hold = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      n_checks++;
      if (dut_vec !== 8'h00) $display("FAIL reset_release cyc=%0d got=%b exp=%b", k, dut_vec, 8'h00); else n_pass++;
    end
  endtask

  task automatic test_manual_step();
    int         exp_sel[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_oh[5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int hi, lo, npulse;
    for (int i = 0; i < 5; i++) begin
      hi = $urandom_range(6, 12);
      lo = $urandom_range(8, 14);
      npulse = 0;
      for (int k = 0; k < hi + lo; k++) begin
        btn_step = (k < hi);
        cyc();
        npulse += int'(step_pulse);
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL manual_cycle press=%0d got=%b exp=%b", i, dut_vec, exp_vec()); else n_pass++;
      end
      n_checks++;
      if ({en, sel, sel_onehot} !== {1'b1, 2'(exp_sel[i]), exp_oh[i]})
        $display("FAIL manual_sel press=%0d got=%b exp=%b", i, {en, sel, sel_onehot}, {1'b1, 2'(exp_sel[i]), exp_oh[i]});
      else n_pass++;
      n_checks++;
      if (npulse !== (i == 0 ? 0 : 1)) $display("FAIL manual_pulses press=%0d got=%0d exp=%0d", i, npulse, (i == 0 ? 0 : 1)); else n_pass++;
    end
  endtask

  task automatic test_bounce();
    int sel0, npulse, left;
    sel0 = m_sel;
    npulse = 0;
    left = 0;
    for (int k = 0; k < 30; k++) begin
      if (left == 0) begin
        btn_step = ~btn_step;
        left = $urandom_range(1, 3);
      end
      left--;
      cyc();
      npulse += int'(step_pulse);
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL bounce_cycle got=%b exp=%b", dut_vec, exp_vec()); else n_pass++;
    end
    n_checks++;
    if (npulse !== 0 || sel !== 2'(sel0)) $display("FAIL bounce_reject got sel=%0d pulses=%0d exp sel=%0d pulses=0", sel, npulse, sel0); else n_pass++;
    npulse = 0;
    for (int k = 0; k < 20; k++) begin
      btn_step = (k < 8);
      cyc();
      npulse += int'(step_pulse);
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL bounce_final got=%b exp=%b", dut_vec, exp_vec()); else n_pass++;
    end
    n_checks++;
    if (npulse !== 1 || sel !== 2'((sel0 + 1) % 4)) $display("FAIL bounce_advance got sel=%0d pulses=%0d exp sel=%0d pulses=1", sel, npulse, (sel0 + 1) % 4); else n_pass++;
  endtask

  task automatic test_auto_scan();
    int pt[$];
    int ps[$];
    int n;
    rst_n = 1'b0;
    model_reset();
    cyc(); cyc();
    rst_n = 1'b1;
    auto_en = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    n_checks++;
    if ({en, sel, sel_onehot} !== 7'b1_00_0001) $display("FAIL auto_enter got=%b exp=%b", {en, sel, sel_onehot}, 7'b1_00_0001); else n_pass++;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (step_pulse === 1'b1) begin pt.push_back(k); ps.push_back(int'(sel)); end
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL auto_cycle got=%b exp=%b", dut_vec, exp_vec()); else n_pass++;
    end
    n_checks++;
    if (pt.size() < 5) $display("FAIL auto_pulse_count got=%0d exp>=5", pt.size()); else n_pass++;
    n = (pt.size() < 5) ? pt.size() : 5;
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (ps[i] !== (i + 1) % 4) $display("FAIL auto_seq idx=%0d got=%0d exp=%0d", i, ps[i], (i + 1) % 4); else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (pt[i] - pt[i-1] !== DIV_MAX + 1) $display("FAIL auto_period idx=%0d got=%0d exp=%0d", i, pt[i] - pt[i-1], DIV_MAX + 1); else n_pass++;
      end
    end
  endtask

  task automatic test_hold();
    int p, s0, npulse, found;
    repeat ($urandom_range(0, 6)) cyc();
    p = m_scan;
    s0 = m_sel;
    npulse = 0;
    hold = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      npulse += int'(step_pulse);
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL hold_cycle got=%b exp=%b", dut_vec, exp_vec()); else n_pass++;
    end
    n_checks++;
    if (npulse !== 0 || sel !== 2'(s0)) $display("FAIL hold_freeze got sel=%0d pulses=%0d exp sel=%0d pulses=0", sel, npulse, s0); else n_pass++;
    hold = 1'b0;
    found = -1;
    for (int k = 1; k <= 10 && found < 0; k++) begin
      cyc();
      if (step_pulse === 1'b1) found = k;
    end
    n_checks++;
    if (found !== DIV_MAX + 1 - p) $display("FAIL hold_resume got=%0d exp=%0d", found, DIV_MAX + 1 - p); else n_pass++;
  endtask

  task automatic test_mode_exit_and_reset();
    int s1, npulse;
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      if (m_scan == 3) hit = 1'b1; else cyc();
    end
    n_checks++;
    if (!hit) $display("FAIL exit_presc3 got=not_reached exp=3"); else n_pass++;
    auto_en = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    s1 = m_sel;
    npulse = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      npulse += int'(step_pulse);
    end
    n_checks++;
    if (npulse !== 0 || sel !== 2'(s1) || en !== 1'b1) $display("FAIL exit_hold got sel=%0d en=%0d pulses=%0d exp sel=%0d en=1 pulses=0", sel, en, npulse, s1); else n_pass++;
    for (int k = 0; k < 20; k++) begin
      btn_step = (k < 8);
      cyc();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL exit_press_cycle got=%b exp=%b", dut_vec, exp_vec()); else n_pass++;
    end
    n_checks++;
    if (sel !== 2'((s1 + 1) % 4)) $display("FAIL exit_press got=%0d exp=%0d", sel, (s1 + 1) % 4); else n_pass++;
    auto_en = 1'b1;
    repeat ($urandom_range(8, 14)) cyc();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec !== 8'h00) $display("FAIL midscan_reset got=%b exp=%b", dut_vec, 8'h00); else n_pass++;
    @(negedge clk);
    auto_en = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL post_reset got=%b exp=%b", dut_vec, exp_vec()); else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_manual_step();
    test_bounce();
    test_auto_scan();
    test_hold();
    test_mode_exit_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
